// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/MDU writebacks onto one regfile write port and scoreboards long-latency destinations
module wb_arbiter #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int REG_DATA_W = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_addr,
  input  logic [REG_DATA_W-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_addr,
  input  logic [REG_DATA_W-1:0] i_lsu_data,
  output logic                  o_lsu_ready,
  input  logic                  i_mdu_valid,
  input  logic [REG_ADDR_W-1:0] i_mdu_addr,
  input  logic [REG_DATA_W-1:0] i_mdu_data,
  output logic                  o_mdu_ready,
  output logic                  o_wb_stall,
  input  logic                  i_iss_valid,
  input  logic [REG_ADDR_W-1:0] i_iss_addr,
  input  logic [REG_ADDR_W-1:0] i_chk_addr1,
  input  logic [REG_ADDR_W-1:0] i_chk_addr2,
  output logic                  o_chk_busy1,
  output logic                  o_chk_busy2,
  output logic                  o_w_en,
  output logic [REG_ADDR_W-1:0] o_w_addr,
  output logic [REG_DATA_W-1:0] o_w_data
);
  localparam logic [3:0] LIM = 4'(STARVE_LIM);
  localparam logic [REG_NUM-1:0] ONE = REG_NUM'(1);
  logic                  r_rr;
  logic                  r_starve;
  logic [3:0]            r_cnt;
  logic [REG_NUM-1:0]    r_busy;
  logic                  r_w_en;
  logic [REG_ADDR_W-1:0] r_w_addr;
  logic [REG_DATA_W-1:0] r_w_data;
  logic                  w_slow_any;
  logic                  w_gnt_lsu;
  logic                  w_slow_win;
  logic                  w_win;
  logic                  w_wr;
  logic [REG_ADDR_W-1:0] w_slow_addr;
  logic [REG_DATA_W-1:0] w_slow_data;
  logic [REG_ADDR_W-1:0] w_win_addr;
  logic [REG_DATA_W-1:0] w_win_data;
  logic [3:0]            w_cnt_nxt;
  logic [REG_NUM-1:0]    w_set;
  logic [REG_NUM-1:0]    w_clr;
  logic [REG_NUM-1:0]    w_busy_nxt;

  // Pick the slow requester (round-robin on conflict) and decide whether it beats the ALU this cycle
  always_comb begin
    w_slow_any  = i_lsu_valid | i_mdu_valid;
    w_gnt_lsu   = i_lsu_valid & (~i_mdu_valid | ~r_rr);
    w_slow_win  = w_slow_any & (r_starve | ~i_alu_valid);
    o_wb_stall  = r_starve & w_slow_any;
    o_lsu_ready = w_slow_win & w_gnt_lsu;
    o_mdu_ready = w_slow_win & ~w_gnt_lsu;
    w_slow_addr = w_gnt_lsu ? i_lsu_addr : i_mdu_addr;
    w_slow_data = w_gnt_lsu ? i_lsu_data : i_mdu_data;
    w_win       = w_slow_win | i_alu_valid;
    w_win_addr  = w_slow_win ? w_slow_addr : i_alu_addr;
    w_win_data  = w_slow_win ? w_slow_data : i_alu_data;
    w_wr        = w_win & (|w_win_addr);
  end

  // Next starvation count and scoreboard image; a same-cycle issue overrides the clear since the newer op owns the register
  always_comb begin
    w_cnt_nxt  = (w_slow_win | ~w_slow_any) ? 4'd0 : (r_cnt == LIM ? LIM : r_cnt + 4'd1);
    w_set      = i_iss_valid ? (ONE << i_iss_addr) : '0;
    w_clr      = w_slow_win ? (ONE << w_slow_addr) : '0;
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~ONE;
  end

  // Source-operand hazard lookup straight from the scoreboard; bit 0 never sets so x0 reads idle
  always_comb begin
    o_chk_busy1 = r_busy[i_chk_addr1];
    o_chk_busy2 = r_busy[i_chk_addr2];
    o_w_en      = r_w_en;
    o_w_addr    = r_w_addr;
    o_w_data    = r_w_data;
  end

  // Arbitration state, scoreboard and the registered regfile write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr     <= 1'b0;
      r_starve <= 1'b0;
      r_cnt    <= 4'd0;
      r_busy   <= '0;
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_rr     <= o_lsu_ready ? 1'b1 : (o_mdu_ready ? 1'b0 : r_rr);
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_cnt_nxt == LIM;
      r_busy   <= w_busy_nxt;
      r_w_en   <= w_wr;
      r_w_addr <= w_wr ? w_win_addr : r_w_addr;
      r_w_data <= w_wr ? w_win_data : r_w_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors, directed corner sequences and randomized traffic against a reference model
module tb_wb_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic av = 0, lv = 0, mv = 0, iv = 0;
  logic [4:0] aa = 0, la = 0, ma = 0, ia = 0, c1 = 0, c2 = 0;
  logic [31:0] ad = 0, ld = 0, md = 0;
  logic lr, mr, st, b1, b2, wen;
  logic [4:0] wa;
  logic [31:0] wd;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.REG_NUM(32), .REG_ADDR_W(5), .REG_DATA_W(32), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(av), .i_alu_addr(aa), .i_alu_data(ad),
    .i_lsu_valid(lv), .i_lsu_addr(la), .i_lsu_data(ld), .o_lsu_ready(lr),
    .i_mdu_valid(mv), .i_mdu_addr(ma), .i_mdu_data(md), .o_mdu_ready(mr),
    .o_wb_stall(st), .i_iss_valid(iv), .i_iss_addr(ia),
    .i_chk_addr1(c1), .i_chk_addr2(c2), .o_chk_busy1(b1), .o_chk_busy2(b2),
    .o_w_en(wen), .o_w_addr(wa), .o_w_data(wd)
  );

  // Reference model: who has been waiting how long, who was served last, which registers await a result
  bit m_busy[32];
  bit m_last_lsu;
  int m_lost;
  bit m_wen;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  bit e_lr, e_mr, e_st;
  logic s_lr, s_mr, s_st, s_b1, s_b2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_last_lsu = 0;
    m_lost = 0;
    m_wen = 0;
    m_wa = 0;
    m_wd = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    {av, lv, mv, iv} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: inputs already driven after a negedge; checks combinational outputs, then registered ones after the edge
  task automatic tick();
    bit any, forced, pick_lsu, served, win;
    logic [4:0] w_a;
    logic [31:0] w_d;
    any = lv || mv;
    forced = any && (m_lost == LIM);
    pick_lsu = lv && (!mv || !m_last_lsu);
    served = any && (forced || !av);
    e_lr = served && pick_lsu;
    e_mr = served && !pick_lsu;
    e_st = forced;
    #1;
    s_lr = lr; s_mr = mr; s_st = st; s_b1 = b1; s_b2 = b2;
    check("lsu_ready", lr, e_lr);
    check("mdu_ready", mr, e_mr);
    check("wb_stall", st, e_st);
    check("chk_busy1", b1, m_busy[c1]);
    check("chk_busy2", b2, m_busy[c2]);
    win = served || av;
    w_a = served ? (pick_lsu ? la : ma) : aa;
    w_d = served ? (pick_lsu ? ld : md) : ad;
    @(posedge clk);
    if (e_lr) m_last_lsu = 1;
    if (e_mr) m_last_lsu = 0;
    m_lost = (served || !any) ? 0 : (m_lost < LIM ? m_lost + 1 : LIM);
    if (served) m_busy[w_a] = 0;
    if (iv && ia != 0) m_busy[ia] = 1;
    m_wen = win && w_a != 0;
    if (m_wen) begin
      m_wa = w_a;
      m_wd = w_d;
    end
    #1;
    check("w_en", wen, m_wen);
    check("w_addr", wa, m_wa);
    check("w_data", wd, m_wd);
    @(negedge clk);
  endtask

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic iv; logic [4:0] ia; logic [4:0] c1; logic [4:0] c2;
    logic lr; logic mr; logic st; logic b1; logic b2; logic wen; logic [4:0] wa; logic [31:0] wd;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0,     0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    tbl[1] = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 3, 32'h33, 1, 7, 7, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11};
    tbl[2] = '{0, 0, 0,            1, 2, 32'h22, 1, 3, 32'h33, 1, 3, 7, 3, 1, 0, 0, 1, 0, 1, 2, 32'h22};
    tbl[3] = '{0, 0, 0,            0, 0, 0,     1, 3, 32'h33, 0, 0, 3, 7, 0, 1, 0, 1, 1, 1, 3, 32'h33};
    tbl[4] = '{0, 0, 0,            0, 0, 0,     1, 7, 32'h77, 1, 7, 7, 3, 0, 1, 0, 1, 0, 1, 7, 32'h77};
    tbl[5] = '{0, 0, 0,            0, 0, 0,     0, 0, 0,     0, 0, 7, 3, 0, 0, 0, 1, 0, 0, 7, 32'h77};
    tbl[6] = '{0, 0, 0,            1, 7, 32'h70, 0, 0, 0,     0, 0, 7, 0, 1, 0, 0, 1, 0, 1, 7, 32'h70};
    tbl[7] = '{0, 0, 0,            1, 0, 32'h1234, 0, 0, 0,   1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 7, 32'h70};
    tbl[8] = '{0, 0, 0,            0, 0, 0,     0, 0, 0,     0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 7, 32'h70};
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_w_en", wen, 1'b0);
    check("reset_w_addr", wa, 5'd0);
    check("reset_w_data", wd, 32'd0);
    check("reset_ready", {lr, mr, st}, 3'b000);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      {av, aa, ad, lv, la, ld, mv, ma, md, iv, ia, c1, c2} =
        {tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld,
         tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].iv, tbl[i].ia, tbl[i].c1, tbl[i].c2};
      tick();
      check($sformatf("row%0d_lsu_ready", i), s_lr, tbl[i].lr);
      check($sformatf("row%0d_mdu_ready", i), s_mr, tbl[i].mr);
      check($sformatf("row%0d_stall", i), s_st, tbl[i].st);
      check($sformatf("row%0d_busy1", i), s_b1, tbl[i].b1);
      check($sformatf("row%0d_busy2", i), s_b2, tbl[i].b2);
      check($sformatf("row%0d_w_en", i), wen, tbl[i].wen);
      check($sformatf("row%0d_w_addr", i), wa, tbl[i].wa);
      check($sformatf("row%0d_w_data", i), wd, tbl[i].wd);
    end
    iv = 0;
    do_reset();
    // ALU always valid with one LSU request waiting: forced through every STARVE_LIM+1 cycles
    lv = 1; la = 20; ld = 32'hA0; c1 = 0; c2 = 0;
    for (int k = 0; k < 10; k++) begin
      av = 1; aa = 5'(10 + k); ad = k;
      tick();
      check($sformatf("starve%0d_stall", k), s_st, (k == 4 || k == 9));
      check($sformatf("starve%0d_lsu_ready", k), s_lr, (k == 4 || k == 9));
      check($sformatf("starve%0d_w_addr", k), wa, k == 4 ? 5'd20 : (k == 9 ? 5'd21 : 5'(10 + k)));
      if (k == 4) begin
        la = 21;
        ld = 32'hA1;
      end
    end
    lv = 0;
    // Asynchronous reset between clock edges with a write in flight and a busy register
    av = 1; aa = 4; ad = 32'h44; iv = 1; ia = 3; c1 = 3;
    tick();
    av = 0; iv = 0;
    #1;
    check("pre_reset_w_en", wen, 1'b1);
    check("pre_reset_busy3", b1, 1'b1);
    #1 rst_n = 0;
    #1;
    check("async_reset_w_en", wen, 1'b0);
    check("async_reset_busy3", b1, 1'b0);
    check("async_reset_w_addr", wa, 5'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    // Randomized traffic; LSU/MDU hold their request until accepted, ALU holds while stalled
    for (int n = 0; n < 400; n++) begin
      if (!(av && e_st)) begin
        av = $urandom_range(0, 3) != 0;
        aa = 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      if (!lv && $urandom_range(0, 2) == 0) begin
        lv = 1; la = 5'($urandom_range(0, 7)); ld = $urandom;
      end
      if (!mv && $urandom_range(0, 2) == 0) begin
        mv = 1; ma = 5'($urandom_range(0, 7)); md = $urandom;
      end
      iv = $urandom_range(0, 3) == 0;
      ia = 5'($urandom_range(0, 7));
      c1 = 5'($urandom_range(0, 7));
      c2 = 5'($urandom_range(0, 7));
      tick();
      if (e_lr) lv = 0;
      if (e_mr) mv = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard in front of the core register file's single write port. It merges three writeback sources onto the one regfile write port, each presenting one request at a time:
- the in-order ALU pipe;
- the load/store unit (LSU) load returns;
- the multi-cycle MUL/DIV unit (MDU).

It also tracks which destination registers still have a long-latency result outstanding, so decode can stall on RAW hazards. It sits between the execute/memory units and the regfile write port (w_en/w_addr/w_data).

## Interface
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
- REG_ADDR_W, 5, register address width
- REG_DATA_W, 32, register data width
- STARVE_LIM, 4, consecutive cycles an LSU/MDU request may lose to the ALU before it is forced through; range 1..15

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU writeback request
- alu_addr_i  in  REG_ADDR_W  ALU destination register
- alu_data_i  in  REG_DATA_W  ALU result
- lsu_valid_i / lsu_addr_i / lsu_data_i  in  1 / REG_ADDR_W / REG_DATA_W  LSU writeback request
- lsu_ready_o  out  1  LSU request accepted this cycle
- mdu_valid_i / mdu_addr_i / mdu_data_i  in  1 / REG_ADDR_W / REG_DATA_W  MDU writeback request
- mdu_ready_o  out  1  MDU request accepted this cycle
- wb_stall_o  out  1  ALU writeback must be held; the pipeline freezes this cycle
- iss_valid_i  in  1  decode issues a long-latency (LSU load or MDU) op
- iss_addr_i  in  REG_ADDR_W  destination of the issued op
- chk_addr1_i, chk_addr2_i  in  REG_ADDR_W  decode source operands to check
- chk_busy1_o, chk_busy2_o  out  1  source has a pending long-latency write (combinational)
- w_en_o  out  1  regfile write enable (registered)
- w_addr_o  out  REG_ADDR_W  regfile write address (registered)
- w_data_o  out  REG_DATA_W  regfile write data (registered)

## Operation
**Slow-request grant.**
- The "slow" requesters are LSU and MDU.
- slow_gnt: the slow requester selected this cycle.
  - If exactly one slow valid is high, it is selected.
  - If both are high, the round-robin pointer picks. rr=0 favours LSU; rr=1 favours MDU.

**Winner selection (combinational).**
- If starve_q=1 and any slow valid is high, slow_gnt wins. wb_stall_o=1, so the ALU is not written and must hold its request.
- Otherwise, if alu_valid_i=1, the ALU wins. lsu_ready_o=mdu_ready_o=0.
- Otherwise, slow_gnt wins.
- wb_stall_o = starve_q & (lsu_valid_i | mdu_valid_i). It is never asserted otherwise.

**Handshake.**
- Transfer happens when valid & ready in the same cycle.
- The LSU and MDU must hold valid/addr/data stable until ready.
- ready never depends on the same requester's data.

**Round-robin pointer.**
- After an LSU transfer, rr<=1. After an MDU transfer, rr<=0. Otherwise it holds.

**Starvation counter.**
- cnt increments each cycle in which a slow valid is high and no slow transfer occurs, saturating at STARVE_LIM.
- cnt clears on any slow transfer, and when no slow valid is high.
- starve_q <= (next cnt == STARVE_LIM). It clears on the slow transfer it forces.

**Write port.**
- w_en_o <= winner present & winner addr != 0.
- w_addr_o/w_data_o <= winner addr/data when w_en_o is next 1; otherwise they hold.
- A write to x0 is accepted (ready asserted) but produces no regfile write.

**Scoreboard.**
- One busy bit per register 1..REG_NUM-1. Bit 0 is constant 0.
- Set: iss_valid_i & iss_addr_i != 0 sets busy[iss_addr_i] next cycle.
- Clear: a slow transfer to addr A clears busy[A] next cycle. ALU writes never clear busy bits.
- Set and clear of the same register in the same cycle: set wins, because a newer op owns the register.
- Issuing to an already-busy register leaves it busy. Decode must not issue a second long op to a busy destination; the scoreboard has no counting.
- chk_busyN_o = busy[chk_addrN_i]. Checking x0 always returns 0.

## Timing
- Reset values:
  - w_en_o=0, w_addr_o=0, w_data_o=0
  - all busy=0, rr=0, cnt=0, starve_q=0
  - wb_stall_o=0, lsu_ready_o=0, mdu_ready_o=0
- Reset asserted mid-operation:
  - All pending state is discarded immediately (asynchronous), including any in-flight w_en_o.
  - Requesters must re-present after reset.
- Latency: request accepted in cycle N → w_en_o/w_addr_o/w_data_o valid in cycle N+1. Busy update is visible on chk_busy in N+1.
- ready and wb_stall_o are combinational from the valids and registered state, with no registered delay.
- Throughput: one writeback per cycle, sustained.
- Worst-case slow-request wait: STARVE_LIM+1 cycles with the ALU continuously valid and one slow requester. With both slow requesters waiting, the second is served within 2·(STARVE_LIM+1) cycles.

## Test plan
- **ALU only:** alu_valid=1, addr=5, data=0xDEADBEEF at cycle N → w_en_o=1, w_addr_o=5, w_data_o=0xDEADBEEF at N+1; both ready outputs stay 0.
- **Simultaneous ALU/LSU/MDU, ALU dropping after one cycle:**
  - Cycle 1: ALU written.
  - Cycle 2: LSU written (rr=0).
  - Cycle 3: MDU written.
  - The w_addr_o sequence matches; each ready is a 1-cycle pulse.
- **Starvation, STARVE_LIM=4:** ALU continuously valid, LSU valid from cycle 0.
  - Cycles 0–3: ALU writes.
  - Cycle 4: wb_stall_o=1 and lsu_ready_o=1.
  - Cycle 5: w_addr_o = LSU address.
  - cnt is back to 0 afterwards.
- **Scoreboard:**
  - Issue x7 → chk_busy1_o=1 for chk_addr1=7 next cycle.
  - MDU writes x7 while iss_valid_i also targets x7 → busy stays 1.
  - Later LSU write to x7 with no issue → busy 0.
- **x0:**
  - LSU writes addr 0 with data 0x1234 → lsu_ready_o=1, w_en_o stays 0.
  - Issue to x0 → chk_busy for x0 stays 0.
- **Reset mid-stream:** assert rst_n=0 while w_en_o=1 and busy[3]=1 → w_en_o=0 and busy[3]=0 immediately, without waiting for a clock edge.
